// File: rtl/arbitro_memoria_datos_pkg.sv
// arbitro_memoria_datos_pkg: shared encodings for the data-memory arbiter
package arbitro_memoria_datos_pkg;
  typedef enum logic {CPU_PRI = 1'b0, EXT_PRI = 1'b1} prio_t;
  localparam logic [3:0] WME_NONE = 4'b0000;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/arbitro_memoria_datos_contador.sv
// contador_saturado: enabled up-counter with sync reset that sticks at all-ones
module contador_saturado #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : (en && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: CPU-priority data-memory arbiter with starvation escape for an external port
module arbitro_memoria_datos
  import arbitro_memoria_datos_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             cpu_req,
  input  logic [3:0]       cpu_wme,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             ext_valid,
  input  logic [3:0]       ext_wme,
  input  logic [31:0]      ext_addr,
  input  logic [31:0]      ext_wdata,
  output logic             ext_ready,
  output logic [31:0]      ext_rdata,
  output logic             ext_rvalid,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wme,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  prio_t      st;
  logic [3:0] streak;
  logic       grant_cpu, grant_ext, ext_rd;
  always_comb begin
    grant_ext = !Reset && ext_valid && (!cpu_req || st == EXT_PRI);
    grant_cpu = !Reset && cpu_req && !grant_ext;
    ext_rd    = grant_ext && ext_wme == WME_NONE;
  end
  assign cpu_stall = cpu_req && !grant_cpu && !Reset;
  assign ext_ready = grant_ext;
  assign cpu_rdata = mem_rdata;
  assign mem_addr  = grant_ext ? ext_addr : cpu_addr;
  assign mem_wdata = grant_ext ? ext_wdata : cpu_wdata;
  assign mem_wme   = grant_ext ? ext_wme : grant_cpu ? cpu_wme : WME_NONE;
  // EXT_PRI lasts until the external port is served or withdraws
  always_ff @(posedge CLK) begin
    if (Reset) begin
      st         <= CPU_PRI;
      streak     <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_rd;
      if (ext_rd) ext_rdata <= mem_rdata;
      streak <= (grant_cpu && ext_valid) ? streak + 4'd1 : '0;
      st <= (st == CPU_PRI)
          ? ((grant_cpu && ext_valid && streak + 4'd1 == SMAX) ? EXT_PRI : CPU_PRI)
          : ((grant_ext || !ext_valid) ? CPU_PRI : EXT_PRI);
    end
  end
  contador_saturado #(.W(CNT_W)) u_stall_cnt (
    .clk(CLK),
    .rst(Reset),
    .en (cpu_stall),
    .q  (stall_count)
  );
endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// tb_arbitro_memoria_datos: random and directed stimulus against a queue-free behavioural arbiter model
module tb_arbitro_memoria_datos;
  localparam int SM = 4;
  localparam int CW = 3;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, ext_valid = 0;
  logic [3:0] cpu_wme = 0, ext_wme = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, ext_ready, ext_rvalid;
  logic [3:0] mem_wme;
  logic [CW-1:0] stall_count;
  logic [31:0] ram [64] = '{default: '0};
  logic [31:0] ref_mem [64] = '{default: '0};
  int errs = 0, checks = 0;
  int m_waits = 0, m_cnt = 0;
  logic m_rv = 0, m_gext_q = 0, m_stall_q = 0;
  logic [31:0] m_rd = 0;
  bit run = 1;

  arbitro_memoria_datos #(.STARVE_MAX(SM), .CNT_W(CW)) dut (
    .CLK(clk), .Reset(rst),
    .cpu_req(cpu_req), .cpu_wme(cpu_wme), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_wme(ext_wme), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wme(mem_wme), .mem_rdata(mem_rdata),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // memory stand-in: combinational read, byte-enabled write
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_wme != 0) ram[mem_addr[7:2]] <= merge(ram[mem_addr[7:2]], mem_wdata, mem_wme);

  // model: ext wins a conflict once it has waited SM conflicting CPU grants
  always @(negedge clk) if (run) begin : cmp
    logic ge, gc, sx;
    logic [31:0] ea;
    ge = !rst && ext_valid && (!cpu_req || m_waits >= SM);
    gc = !rst && cpu_req && !ge;
    sx = !rst && cpu_req && !gc;
    ea = ge ? ext_addr : cpu_addr;
    chk("ext_ready", ext_ready, ge);
    chk("cpu_stall", cpu_stall, sx);
    chk("mem_wme", mem_wme, ge ? ext_wme : gc ? cpu_wme : 4'h0);
    chk("mem_addr", mem_addr, ea);
    if (ge || gc) chk("mem_wdata", mem_wdata, ge ? ext_wdata : cpu_wdata);
    chk("cpu_rdata", cpu_rdata, ref_mem[ea[7:2]]);
    chk("ext_rvalid", ext_rvalid, m_rv);
    chk("ext_rdata", ext_rdata, m_rd);
    chk("stall_count", stall_count, m_cnt);
    if (rst) begin
      m_waits = 0; m_rv = 0; m_rd = 0; m_cnt = 0;
    end else begin
      m_rv = ge && ext_wme == 0;
      if (m_rv) m_rd = ref_mem[ext_addr[7:2]];
      if (ge || gc) ref_mem[ea[7:2]] = merge(ref_mem[ea[7:2]], ge ? ext_wdata : cpu_wdata, ge ? ext_wme : cpu_wme);
      m_waits = (gc && ext_valid) ? m_waits + 1 : 0;
      if (sx && m_cnt < 2**CW - 1) m_cnt++;
    end
    m_gext_q = ge;
    m_stall_q = sx;
  end

  task automatic drive(input bit r, input bit cr, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit ev, input logic [3:0] ew, input logic [31:0] xa, input logic [31:0] xd);
    @(posedge clk); #1;
    rst = r; cpu_req = cr; cpu_wme = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_valid = ev; ext_wme = ew; ext_addr = xa; ext_wdata = xd;
    @(negedge clk); #1;
  endtask

  function automatic logic [3:0] pick_wme();
    return ($urandom_range(0, 2) == 0) ? 4'hF : ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
  endfunction

  initial begin
    drive(1, 1, 4'hF, 32'h10, 32'h1, 1, 4'hF, 32'h20, 32'h2);
    chk("rst_mem_wme", mem_wme, 0);
    chk("rst_ext_ready", ext_ready, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    drive(1, 1, 4'hF, 32'h10, 32'h1, 1, 4'hF, 32'h20, 32'h2);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_count", stall_count, 0);
    drive(0, 0, 0, 0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    chk("ext_wr_ready", ext_ready, 1);
    drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("cpu_load", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_nostall", cpu_stall, 0);
    chk("count_zero", stall_count, 0);
    drive(0, 0, 0, 0, 0, 1, 4'hF, 32'h20, 32'h12345678);
    chk("ext_wr2_ready", ext_ready, 1);
    chk("ext_wr2_wme", mem_wme, 4'hF);
    drive(0, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    chk("cpu_load_20", cpu_rdata, 32'h12345678);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    chk("ext_rd_ready", ext_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ext_rvalid_1", ext_rvalid, 1);
    chk("ext_rdata", ext_rdata, 32'h12345678);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ext_rvalid_0", ext_rvalid, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      chk("starve_ready", ext_ready, i % 5 == 0);
      chk("starve_stall", cpu_stall, i % 5 == 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("count_after_10", stall_count, 2);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("count_saturated", stall_count, 7);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    drive(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    chk("extpri_rst_wme", mem_wme, 0);
    chk("extpri_rst_ready", ext_ready, 0);
    chk("extpri_rst_stall", cpu_stall, 0);
    drive(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    chk("extpri_rst_rvalid", ext_rvalid, 0);
    chk("extpri_rst_count", stall_count, 0);
    drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    chk("post_rst_cpu_wins", ext_ready, 0);
    chk("post_rst_nostall", cpu_stall, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h10, 0);
    chk("pre_rst_read", ext_ready, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("no_rvalid_after_rst", ext_rvalid, 0);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if (!m_stall_q) begin
        cpu_req = $urandom_range(0, 3) != 0;
        cpu_wme = pick_wme();
        cpu_addr = $urandom & 32'hFF;
        cpu_wdata = $urandom;
      end
      if (!ext_valid || m_gext_q) begin
        ext_valid = $urandom_range(0, 1) != 0;
        ext_wme = pick_wme();
        ext_addr = $urandom & 32'hFF;
        ext_wdata = $urandom;
      end
    end
    @(negedge clk); #1;
    run = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/arbitro_memoria_datos.md
Name: arbitro_memoria_datos

Overview:
- Arbitrates single-port data memory (Memoria_Datos) access between the CPU load/store path and an external loader/debug port (e.g. a UART program loader).
- The CPU has priority by default. A starvation counter guarantees the external port one access after at most STARVE_MAX consecutive conflicting CPU grants.
- Sits between the Main ALU/regfile outputs and Memoria_Datos.
- cpu_stall feeds the top-level enable gating of RegPC and regfile wre.

Parameters:
- STARVE_MAX, 4, max consecutive CPU grants while ext_valid is pending; legal range 1..15.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU load/store active this cycle.
- cpu_wme  in  4  CPU byte write enables (0000 = load).
- cpu_addr  in  32  CPU byte address (MainOut).
- cpu_wdata  in  32  CPU store data (do2).
- cpu_rdata  out  32  memory word to CPU load path, combinational passthrough.
- cpu_stall  out  1  CPU must hold PC and suppress writeback this cycle.
- ext_valid  in  1  external request valid.
- ext_wme  in  4  external byte write enables.
- ext_addr  in  32  external byte address.
- ext_wdata  in  32  external write data.
- ext_ready  out  1  external request accepted this cycle.
- ext_rdata  out  32  registered read data.
- ext_rvalid  out  1  ext_rdata valid, one-cycle pulse.
- mem_addr  out  32  to memory address.
- mem_wdata  out  32  to memory datain.
- mem_wme  out  4  to memory wme.
- mem_rdata  in  32  {do3,do2,do1,do0} from memory, combinational read.
- stall_count  out  CNT_W  saturating count of cpu_stall cycles.

Behaviour:
- Priority FSM has two states: CPU_PRI (reset state) and EXT_PRI. A streak counter (4 bits) counts consecutive CPU grants while ext_valid=1.
- Grant is decided combinationally each cycle from the registered state:
  - Only cpu_req set -> grant CPU.
  - Only ext_valid set -> grant EXT.
  - Both set -> CPU in CPU_PRI, EXT in EXT_PRI.
  - Neither set -> no grant; mem_wme=0000, mem_addr=cpu_addr.
- ext_ready = grant_ext. An ext transfer completes in the same cycle as valid&ready. The ext side must hold its request until ready.
- cpu_stall = cpu_req & ~grant_cpu. With no ext traffic the CPU never stalls (zero added latency).
- Mux outputs:
  - grant_cpu -> mem_* = cpu_*.
  - grant_ext -> mem_* = ext_*.
  - cpu_rdata = mem_rdata always.
- Read response: on grant_ext with ext_wme=0000, ext_rdata <= mem_rdata and ext_rvalid <= 1 at the next edge; otherwise ext_rvalid <= 0. Ext writes produce no rvalid.
- Streak counter:
  - On grant_cpu with ext_valid=1: streak <= streak+1.
  - When ext_valid=0 or on grant_ext: streak <= 0.
- Transition CPU_PRI -> EXT_PRI when streak+1 == STARVE_MAX on a conflicting CPU grant.
- Transition EXT_PRI -> CPU_PRI after one grant_ext, so ext gets exactly one access per starvation episode.
- If ext_valid drops while in EXT_PRI: return to CPU_PRI and clear streak.
- stall_count increments on each cycle with cpu_stall=1 and saturates at 2^CNT_W-1 (no wrap).
- Reset (synchronous):
  - state=CPU_PRI, streak=0, ext_rvalid=0, ext_rdata=0, stall_count=0.
  - While Reset=1, mem_wme is forced to 0000, ext_ready=0 and cpu_stall=0.
  - A read granted in the cycle before Reset asserts yields no rvalid after reset.
- A CPU store that is stalled is re-presented by the CPU next cycle. The arbiter does not buffer CPU requests.

Decomposition:
- Shared package holds the state encoding (CPU_PRI=1'b0, EXT_PRI=1'b1), the WME_NONE=4'b0000 constant and the STARVE_MAX default.
- One natural sub-module: contador_saturado (parameterised width, enable, sync reset) for stall_count. It is reusable for other performance counters.
- Muxing reuses the existing Mux_2a1_32bits.

Test Plan:
- Ext idle, CPU load cpu_addr=0x10, mem word 0xDEADBEEF -> cpu_rdata=0xDEADBEEF same cycle, cpu_stall=0, stall_count stays 0.
- Ext write only: ext_addr=0x20, ext_wdata=0x12345678, ext_wme=1111 -> ext_ready=1 same cycle, mem_wme=1111; a later CPU load of 0x20 returns 0x12345678.
- Ext read of 0x20 -> ext_rvalid=1 with ext_rdata=0x12345678 exactly one cycle after ready; rvalid=0 the following cycle.
- Continuous cpu_req plus ext_valid, STARVE_MAX=4 -> CPU granted 4 cycles, then ext_ready=1 and cpu_stall=1 on cycle 5; pattern repeats every 5 cycles; stall_count=2 after 10 cycles.
- Reset asserted while ext_valid=1 in EXT_PRI -> mem_wme=0000, ext_ready=0, ext_rvalid=0, stall_count=0; after release the CPU wins the first conflict.
- Force stall_count=CNT_W ones (small CNT_W=3 build) with continuous stalls -> holds at 7, no wrap.
